// File: rtl/vga_capture.sv
// vga_capture: sink side of the 640x480 VGA link. Samples sync and colour from
// the source, verifies 800x525 line/frame timing, then writes every active
// pixel of a verified frame into a frame buffer as {B,G,R}.
module vga_capture #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACT_START = 145,
  parameter int H_ACT_LEN   = 640,
  parameter int V_ACT_START = 32,
  parameter int V_ACT_LEN   = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        HS,
  input  logic        VS,
  input  logic [3:0]  R,
  input  logic [3:0]  G,
  input  logic [3:0]  B,
  output logic        wr_en,
  output logic [18:0] wr_addr,
  output logic [11:0] wr_data,
  output logic        locked,
  output logic        frame_done,
  output logic        err
);

  typedef enum logic [1:0] {HUNT, SYNC, LOCK} state_t;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } pins_t;

  // Expected pre-update counter values at the sync edges, and the capture window.
  localparam logic [9:0]  H_LINE_OK  = 10'(H_TOTAL - 2);
  localparam logic [9:0]  V_FRAME_OK = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_FIRST    = 10'(H_ACT_START);
  localparam logic [9:0]  H_LAST     = 10'(H_ACT_START + H_ACT_LEN - 1);
  localparam logic [9:0]  V_FIRST    = 10'(V_ACT_START);
  localparam logic [9:0]  V_LAST     = 10'(V_ACT_START + V_ACT_LEN - 1);
  localparam logic [18:0] PIX_LAST   = 19'(H_ACT_LEN * V_ACT_LEN - 1);

  pins_t       s1;
  logic        s2_hs;
  logic        s2_vs;
  logic        hs_fall_q;
  logic [9:0]  hcnt;
  logic [9:0]  vcnt;
  logic [18:0] pix;
  logic        armed;
  state_t      state;

  logic hs_fall;
  logic vs_rise;
  logic line_bad;
  logic frame_bad;
  logic fail;
  logic capture;

  // Edge detection on the two-stage sample; sync polarity is fixed.
  assign hs_fall   = s2_hs & ~s1.hs;
  assign vs_rise   = ~s2_vs & s1.vs;
  assign line_bad  = hs_fall & (hcnt != H_LINE_OK);
  assign frame_bad = vs_rise & (vcnt != V_FRAME_OK);
  // A line fault and a frame fault in the same cycle are one timing failure.
  assign fail      = line_bad | frame_bad;
  assign capture   = armed && (state == LOCK) &&
                     (hcnt >= H_FIRST) && (hcnt <= H_LAST) &&
                     (vcnt >= V_FIRST) && (vcnt <= V_LAST);

  // Input stage: same clock as the source, so plain registers, no synchronizers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1        <= '0;
      s2_hs     <= 1'b0;
      s2_vs     <= 1'b0;
      hs_fall_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make s2 take the old s1, giving a true
      // two-stage pipeline regardless of statement order.
      s1        <= '{hs: HS, vs: VS, r: R, g: G, b: B};
      s2_hs     <= s1.hs;
      s2_vs     <= s1.vs;
      hs_fall_q <= hs_fall;
    end
  end

  // Position counters: hcnt restarts the clk after the registered HS fall, vcnt at VS rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      if (hs_fall_q)       hcnt <= '0;
      else if (hcnt != '1) hcnt <= hcnt + 1'b1;

      if (vs_rise)                     vcnt <= '0;
      else if (hs_fall && vcnt != '1)  vcnt <= vcnt + 1'b1;
    end
  end

  // Lock FSM with registered locked/err; capture is armed on the VS rise that
  // leaves the FSM locked, so the frame right after verification is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= HUNT;
      locked <= 1'b0;
      err    <= 1'b0;
      armed  <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        HUNT: begin
          if (vs_rise) state <= SYNC;
        end
        SYNC: begin
          if (fail) begin
            err   <= 1'b1;
            state <= HUNT;
          end else if (vs_rise) begin
            state  <= LOCK;
            locked <= 1'b1;
            armed  <= en;
          end
        end
        LOCK: begin
          if (fail) begin
            err    <= 1'b1;
            state  <= HUNT;
            locked <= 1'b0;
            armed  <= 1'b0;
          end else if (vs_rise) begin
            armed <= en;
          end
        end
        default: begin
          state  <= HUNT;
          locked <= 1'b0;
          armed  <= 1'b0;
        end
      endcase
    end
  end

  // Write port: one strobe per active cycle carrying that cycle's s1 colour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      pix        <= '0;
      frame_done <= 1'b0;
    end else begin
      wr_en      <= capture & ~fail;
      frame_done <= wr_en && (wr_addr == PIX_LAST);
      if (capture) begin
        wr_addr <= pix;
        wr_data <= {s1.b, s1.g, s1.r};
      end
      if (vs_rise)      pix <= '0;
      else if (capture) pix <= pix + 1'b1;
    end
  end

endmodule
